// File: rtl/seg_scan_pkg.sv
// Shared types, constants and the digit one-hot decode for the seven-segment scanner.
package seg_scan_pkg;

  typedef enum logic {SCAN_BLANK, SCAN_SHOW} scan_state_t;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MAX_DIGITS = 8;

  function automatic logic [MAX_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
    digit_onehot      = '0;
    digit_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-digit slot counter with the BLANK/SHOW state machine of the seven-segment scanner.
module seg_slot_timer
  import seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk_in,
  input  logic reset,
  output logic show,
  output logic slot_end,
  output logic blank_last
);

  logic [CNT_W-1:0] c_q;
  scan_state_t      state_q;

  // Both strobes look at the current count, so they mark the edge that closes the phase.
  assign slot_end   = (c_q == CNT_W'(SCAN_DIV - 1));
  assign blank_last = (c_q == CNT_W'(BLANK_CYCLES - 1));
  assign show       = (state_q == SCAN_SHOW);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      c_q     <= '0;
      state_q <= SCAN_BLANK;
    end else begin
      c_q <= slot_end ? '0 : c_q + 1'b1;
      case (state_q)
        SCAN_BLANK: if (blank_last) state_q <= SCAN_SHOW;
        SCAN_SHOW:  if (slot_end)   state_q <= SCAN_BLANK;
        default:                    state_q <= SCAN_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed digit scanner feeding the seven-segment encoder.
// Optional LEADING_ZERO_BLANK_EN suppresses enables of leading zero digits.
module seven_seg_scanner
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic [NIBBLE_W*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]            dp_in,
  output logic [NIBBLE_W-1:0]          nibble_out,
  output logic                         dp_out,
  output logic [DIGITS-1:0]            digit_en,
  output logic                         frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic show, slot_end, blank_last, show_next, frame_wrap;

  seg_slot_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_slot_timer (
    .clk_in     (clk_in),
    .reset      (reset),
    .show       (show),
    .slot_end   (slot_end),
    .blank_last (blank_last)
  );

  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NIBBLE_W*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]          shadow_dp_q, shadow_dp_d;
  logic [NIBBLE_W-1:0]        nibble_q, nibble_d;
  logic                       dp_q, dp_d;
  logic [DIGITS-1:0]          digit_en_q, digit_en_d;
  logic                       frame_done_q;
  logic [DIGITS-1:0]          visible;

  assign show_next  = blank_last | (show & ~slot_end);
  assign frame_wrap = slot_end && (idx_q == IDX_W'(DIGITS - 1));

  always_comb begin
    idx_d = idx_q;
    if (slot_end) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
  end

  // Latch once per frame, just before digit 0 lights, so a frame never mixes two values.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (blank_last && (idx_q == '0)) begin
      shadow_d    = value;
      shadow_dp_d = dp_in;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_nz;
  always_comb begin
    visible  = '1;
    upper_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_nz   = upper_nz | (shadow_d[NIBBLE_W*i +: NIBBLE_W] != '0);
      visible[i] = upper_nz | shadow_dp_d[i];
    end
  end
`else
  assign visible = '1;
`endif

  // Outputs are computed from next-state so they land on the same edge as the slot phase.
  always_comb begin
    nibble_d   = shadow_d[NIBBLE_W*idx_d +: NIBBLE_W];
    dp_d       = shadow_dp_d[idx_d];
    digit_en_d = show_next ? (DIGITS'(digit_onehot(3'(idx_d))) & visible) : '0;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      nibble_q     <= '0;
      dp_q         <= 1'b0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      nibble_q     <= nibble_d;
      dp_q         <= dp_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_wrap;
    end
  end

  assign nibble_out = nibble_q;
  assign dp_out     = dp_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule
